seq_det_ctrl: RTL and testbench

- Programmable serial bit-pattern detector controller, for match detection on serial input streams.
- Host loads a pattern (length 1..MAX_LEN), a match target and a start command. The block then consumes a valid-qualified bit stream, reports every overlapping match and stops when the target count is reached.
- Replaces per-pattern hardwired detector FSMs with one configurable, sequenced block.

---
 rtl/seq_det_pkg.sv | 29 ++
 rtl/seq_det_ctrl_if.sv | 32 +++
 rtl/seq_match_core.sv | 56 +++++
 rtl/seq_det_ctrl.sv | 121 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  // Widest pattern the mask helper can describe; instances cast down to MAX_LEN.
  localparam int unsigned MAX_SUPPORTED_LEN = 64;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

  function automatic logic [MAX_SUPPORTED_LEN-1:0] low_mask(input int unsigned len);
    logic [MAX_SUPPORTED_LEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_SUPPORTED_LEN; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Host-side configuration, bit stream and status bundle of the pattern detector.
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               start;
  logic               abort;
  logic               bit_valid;
  logic               bit_in;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, bit_valid, bit_in,
    input  cfg_ready, match, match_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, start, abort, bit_valid, bit_in,
    output cfg_ready, match, match_count, busy, done
  );

endinterface

// File: rtl/seq_match_core.sv
// Shift history, fill tracking and masked compare; hit reflects the history after this shift.
module seq_match_core
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W:0]     fill_inc;
  logic               filled;

  assign hist_next = {hist_q[MAX_LEN-2:0], bit_in};
  assign mask      = MAX_LEN'(low_mask(32'(len)));
  // One wider bit so fill+1 cannot wrap when MAX_LEN is 2^k-1.
  assign fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
  assign filled    = fill_inc >= {1'b0, len};
  assign hit       = shift_en && filled && (((hist_next ^ pattern) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_next;
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_inc[LEN_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run sequencer for the pattern detector: config capture, IDLE/RUN/DONE FSM and match counting.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic          clk,
  input logic          reset,
  seq_det_ctrl_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   count_inc;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic cfg_accept;
  logic shift_en;
  logic clear_hist;
  logic hit;

  assign cfg_accept = bus.cfg_valid && cfg_ready_q;
  assign shift_en   = (state_q == ST_RUN) && !bus.abort && bus.bit_valid;
  assign clear_hist = (state_q != ST_RUN) && !bus.abort && bus.start;
  assign count_inc  = (count_q == '1) ? count_q : count_q + CNT_W'(1);

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .clear    (clear_hist),
    .bit_in   (bus.bit_in),
    .pattern  (pattern_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    target_d  = target_q;
    if (cfg_accept) begin
      pattern_d = bus.cfg_pattern;
      len_d     = LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
      target_d  = bus.cfg_target;
    end
  end

  // Abort outranks start, which outranks an incoming bit.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    match_d = 1'b0;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            count_d = '0;
          end
        end
        ST_RUN: begin
          if (shift_en && hit) begin
            match_d = 1'b1;
            count_d = count_inc;
            if ((target_q != '0) && (count_inc == target_q)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d      = (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    cfg_ready_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pattern_q   <= '0;
      len_q       <= LEN_W'(1);
      target_q    <= '0;
      count_q     <= '0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      target_q    <= target_d;
      count_q     <= count_d;
      match_q     <= match_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed scenario bench for seq_det_ctrl with hand-computed expectations.
module tb_seq_det_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_det_ctrl_if #(.MAX_LEN(8), .CNT_W(8)) bus_if ();

  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus_if.cfg_valid   = 1'b0;
    bus_if.cfg_pattern = '0;
    bus_if.cfg_len     = '0;
    bus_if.cfg_target  = '0;
    bus_if.start       = 1'b0;
    bus_if.abort       = 1'b0;
    bus_if.bit_valid   = 1'b0;
    bus_if.bit_in      = 1'b0;
  endtask

  // Each driver sets inputs on the falling edge and returns 1 ns after the rising edge.
  task automatic drive_bit(input logic v, input logic b);
    @(negedge clk);
    bus_if.bit_valid = v;
    bus_if.bit_in    = b;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic configure(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] t, input logic s);
    @(negedge clk);
    bus_if.cfg_valid   = 1'b1;
    bus_if.cfg_pattern = p;
    bus_if.cfg_len     = l;
    bus_if.cfg_target  = t;
    bus_if.start       = s;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic pulse_abort(input logic v, input logic b);
    @(negedge clk);
    bus_if.abort     = 1'b1;
    bus_if.bit_valid = v;
    bus_if.bit_in    = b;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %0b expected 1", bus_if.cfg_ready); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus_if.done); end
    checks++; if (bus_if.match !== 1'b0) begin errors++; $display("FAIL reset_match: got %0b expected 0", bus_if.match); end
    checks++; if (bus_if.match_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus_if.match_count); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic s[8];
    logic m[8];
    s = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    configure(8'b0111, 4'd4, 8'd0, 1'b0);
    pulse_start();
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %0b expected 1", bus_if.busy); end
    checks++; if (bus_if.cfg_ready !== 1'b0) begin errors++; $display("FAIL basic_cfg_ready_run: got %0b expected 0", bus_if.cfg_ready); end
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b1, s[i]);
      checks++; if (bus_if.match !== m[i]) begin errors++; $display("FAIL basic_match bit%0d: got %0b expected %0b", i + 1, bus_if.match, m[i]); end
    end
    checks++; if (bus_if.match_count !== 8'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", bus_if.match_count); end
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_end: got %0b expected 1", bus_if.busy); end
  endtask

  task automatic test_overlap_target();
    logic s[6];
    logic m[6];
    s = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    m = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pulse_abort(1'b0, 1'b0);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", bus_if.busy); end
    configure(8'b101, 4'd3, 8'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive_bit(1'b1, s[i]);
      checks++; if (bus_if.match !== m[i]) begin errors++; $display("FAIL overlap_match bit%0d: got %0b expected %0b", i + 1, bus_if.match, m[i]); end
      if (i == 4) begin
        checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL overlap_done: got %0b expected 1", bus_if.done); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL overlap_busy: got %0b expected 0", bus_if.busy); end
      end
    end
    checks++; if (bus_if.match_count !== 8'd2) begin errors++; $display("FAIL overlap_count: got %0d expected 2", bus_if.match_count); end
    checks++; if (bus_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL overlap_cfg_ready: got %0b expected 1", bus_if.cfg_ready); end
  endtask

  task automatic test_gaps_clamp();
    logic v[4];
    logic m[4];
    v = '{1'b1, 1'b0, 1'b1, 1'b1};
    m = '{1'b1, 1'b0, 1'b1, 1'b1};
    configure(8'b1, 4'd0, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive_bit(v[i], 1'b1);
      checks++; if (bus_if.match !== m[i]) begin errors++; $display("FAIL gap_match cyc%0d: got %0b expected %0b", i + 1, bus_if.match, m[i]); end
    end
    checks++; if (bus_if.match_count !== 8'd3) begin errors++; $display("FAIL gap_count: got %0d expected 3", bus_if.match_count); end
    pulse_abort(1'b0, 1'b0);
    checks++; if (bus_if.match_count !== 8'd3) begin errors++; $display("FAIL abort_count_held: got %0d expected 3", bus_if.match_count); end
    checks++; if (bus_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL abort_cfg_ready: got %0b expected 1", bus_if.cfg_ready); end
    configure(8'hFF, 4'd12, 8'd0, 1'b1);
    checks++; if (bus_if.match_count !== 8'd0) begin errors++; $display("FAIL clamp_count_clear: got %0d expected 0", bus_if.match_count); end
    for (int i = 0; i < 8; i++) begin
      drive_bit(1'b1, 1'b1);
      checks++; if (bus_if.match !== (i == 7)) begin errors++; $display("FAIL clamp_match bit%0d: got %0b expected %0b", i + 1, bus_if.match, (i == 7)); end
    end
  endtask

  task automatic test_abort();
    logic s[4];
    logic m[4];
    s = '{1'b0, 1'b1, 1'b1, 1'b1};
    m = '{1'b0, 1'b0, 1'b0, 1'b1};
    pulse_abort(1'b0, 1'b0);
    configure(8'b0111, 4'd4, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, s[i]);
    pulse_abort(1'b1, 1'b1);
    checks++; if (bus_if.match !== 1'b0) begin errors++; $display("FAIL abort_match: got %0b expected 0", bus_if.match); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL abort_idle_busy: got %0b expected 0", bus_if.busy); end
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL abort_idle_done: got %0b expected 0", bus_if.done); end
    checks++; if (bus_if.match_count !== 8'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", bus_if.match_count); end
    pulse_start();
    checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %0b expected 1", bus_if.busy); end
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b1, s[i]);
      checks++; if (bus_if.match !== m[i]) begin errors++; $display("FAIL restart_match bit%0d: got %0b expected %0b", i + 1, bus_if.match, m[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic s[3];
    logic m[3];
    s = '{1'b0, 1'b1, 1'b0};
    m = '{1'b1, 1'b0, 1'b1};
    checks++; if (bus_if.match_count !== 8'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", bus_if.match_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus_if.match !== 1'b0) begin errors++; $display("FAIL areset_match: got %0b expected 0", bus_if.match); end
    checks++; if (bus_if.match_count !== 8'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", bus_if.match_count); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %0b expected 0", bus_if.busy); end
    checks++; if (bus_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL areset_cfg_ready: got %0b expected 1", bus_if.cfg_ready); end
    @(negedge clk);
    reset = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, s[i]);
      checks++; if (bus_if.match !== m[i]) begin errors++; $display("FAIL len1_match bit%0d: got %0b expected %0b", i + 1, bus_if.match, m[i]); end
    end
    checks++; if (bus_if.match_count !== 8'd2) begin errors++; $display("FAIL len1_count: got %0d expected 2", bus_if.match_count); end
  endtask

  task automatic test_reconfig_done();
    logic m[3];
    m = '{1'b0, 1'b1, 1'b1};
    pulse_abort(1'b0, 1'b0);
    configure(8'b1, 4'd1, 8'd1, 1'b1);
    drive_bit(1'b1, 1'b1);
    checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL reconf_first_done: got %0b expected 1", bus_if.done); end
    configure(8'b11, 4'd2, 8'd0, 1'b1);
    checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL reconf_done_drop: got %0b expected 0", bus_if.done); end
    checks++; if (bus_if.match_count !== 8'd0) begin errors++; $display("FAIL reconf_count_clear: got %0d expected 0", bus_if.match_count); end
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, 1'b1);
      checks++; if (bus_if.match !== m[i]) begin errors++; $display("FAIL reconf_match bit%0d: got %0b expected %0b", i + 1, bus_if.match, m[i]); end
    end
    checks++; if (bus_if.match_count !== 8'd2) begin errors++; $display("FAIL reconf_count: got %0d expected 2", bus_if.match_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_overlap_target();
    test_gaps_clamp();
    test_abort();
    test_async_reset();
    test_reconfig_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
